// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl: rectangle position controller (follow mouse, gravity drop on click, return on next click)
// Optional bounce on impact is enabled by defining DRAW_RECT_CTL_BOUNCE_EN.
module draw_rect_ctl #(
    parameter int SCREEN_W = 1280,
    parameter int SCREEN_H = 1024,
    parameter int RECT_W   = 48,
    parameter int RECT_H   = 64,
    parameter int ACCEL    = 1,
    parameter int VMAX     = 64
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        mouse_left_in,
    input  logic        vsync_in,
    output logic [11:0] xpos_out,
    output logic [11:0] ypos_out,
    output logic        falling_out
);
    localparam logic [11:0] XMAX = 12'(SCREEN_W - RECT_W);
    localparam logic [11:0] YMAX = 12'(SCREEN_H - RECT_H);
    localparam logic [11:0] VMX  = 12'(VMAX);
    localparam logic [11:0] ACC  = 12'(ACCEL);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FALL   = 2'd1;
    localparam logic [1:0] LANDED = 2'd2;
    localparam logic [1:0] RISE   = 2'd3;
    logic [1:0]  state_q, state_d;
    logic [11:0] x_q, x_d, y_q, y_d, vel_q, vel_d;
    logic        left_q, vsync_q, fall_q, fall_d;
    logic        press, tick;
    logic [12:0] vel_inc, y_sum;
    logic [11:0] vel_n, y_fall, x_clamp, y_clamp;
    assign press   = mouse_left_in & ~left_q;
    assign tick    = vsync_in & ~vsync_q;
    assign vel_inc = {1'b0, vel_q} + {1'b0, ACC};
    assign vel_n   = (vel_inc > {1'b0, VMX}) ? VMX : vel_inc[11:0];
    assign y_sum   = {1'b0, y_q} + {1'b0, vel_n};
    assign y_fall  = (y_sum >= {1'b0, YMAX}) ? YMAX : y_sum[11:0];
    assign x_clamp = (xpos_in > XMAX) ? XMAX : xpos_in;
    assign y_clamp = (ypos_in > YMAX) ? YMAX : ypos_in;
    // next-state, position and velocity; a tick only matters while the rect is moving
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vel_d   = vel_q;
        case (state_q)
            IDLE: begin
                x_d = x_clamp;
                y_d = y_clamp;
                if (press) begin
                    state_d = FALL;
                    vel_d   = '0;
                end
            end
            FALL: begin
                if (tick) begin
                    vel_d = vel_n;
                    y_d   = y_fall;
                    if (y_fall == YMAX) begin
`ifdef DRAW_RECT_CTL_BOUNCE_EN
                        if (vel_n >= 12'd4) begin
                            vel_d   = vel_n - (vel_n >> 2);
                            state_d = RISE;
                        end else begin
                            vel_d   = '0;
                            state_d = LANDED;
                        end
`else
                        vel_d   = '0;
                        state_d = LANDED;
`endif
                    end
                end
            end
            LANDED: begin
                vel_d = '0;
                if (press) state_d = IDLE;
            end
`ifdef DRAW_RECT_CTL_BOUNCE_EN
            RISE: begin
                if (tick) begin
                    y_d = (y_q > vel_q) ? y_q - vel_q : '0;
                    if (vel_q <= ACC) begin
                        vel_d   = '0;
                        state_d = FALL;
                    end else begin
                        vel_d = vel_q - ACC;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        fall_d = (state_d == FALL) || (state_d == RISE);
    end
    // state, outputs and edge-detect history
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            vel_q   <= '0;
            fall_q  <= 1'b0;
            left_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            fall_q  <= fall_d;
            left_q  <= mouse_left_in;
            vsync_q <= vsync_in;
        end
    end
    assign xpos_out    = x_q;
    assign ypos_out    = y_q;
    assign falling_out = fall_q;
endmodule

// File: tb/tb_draw_rect_ctl.sv
// tb_draw_rect_ctl: directed and randomized checks of draw_rect_ctl against a behavioural model
module tb_draw_rect_ctl;
    localparam int XMAX = 1232;
    localparam int YMAX = 960;
    localparam int VMAX = 64;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif
    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] xpos_in = '0, ypos_in = '0;
    logic        mouse_left_in = 1'b0, vsync_in = 1'b0;
    logic [11:0] xpos_out, ypos_out;
    logic        falling_out;
    int total = 0, bad = 0;
    int m_st, ex, ey, vel;
    bit ef, pl, pv;

    always #5 pclk = ~pclk;

    draw_rect_ctl dut (
        .pclk(pclk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
        .mouse_left_in(mouse_left_in), .vsync_in(vsync_in),
        .xpos_out(xpos_out), .ypos_out(ypos_out), .falling_out(falling_out)
    );

    function automatic void model_reset();
        m_st = 0; ex = 0; ey = 0; vel = 0; ef = 0; pl = 0; pv = 0;
    endfunction

    // modes: 0 follow mouse, 1 falling, 2 resting on bottom, 3 rising after bounce
    function automatic void model_step(int x, int y, bit l, bit v);
        bit press = l && !pl;
        bit tk = v && !pv;
        pl = l;
        pv = v;
        case (m_st)
            0: begin
                ex = (x > XMAX) ? XMAX : x;
                ey = (y > YMAX) ? YMAX : y;
                if (press) begin m_st = 1; vel = 0; end
            end
            1: if (tk) begin
                vel = (vel + 1 > VMAX) ? VMAX : vel + 1;
                ey = (ey + vel > YMAX) ? YMAX : ey + vel;
                if (ey == YMAX) begin
                    if (BOUNCE && vel >= 4) begin vel = vel - vel / 4; m_st = 3; end
                    else begin vel = 0; m_st = 2; end
                end
            end
            2: if (press) m_st = 0;
            default: if (tk) begin
                ey = (ey > vel) ? ey - vel : 0;
                if (vel <= 1) begin vel = 0; m_st = 1; end
                else vel = vel - 1;
            end
        endcase
        ef = (m_st == 1) || (m_st == 3);
    endfunction

    task automatic cyc(int x, int y, bit l, bit v);
        xpos_in = 12'(x);
        ypos_in = 12'(y);
        mouse_left_in = l;
        vsync_in = v;
        @(posedge pclk);
        model_step(x, y, l, v);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        total += 3;
        if (xpos_out !== 12'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", xpos_out); end
        if (ypos_out !== 12'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", ypos_out); end
        if (falling_out !== 1'b0) begin bad++; $display("FAIL reset_fall got=%b exp=0", falling_out); end
        model_reset();
        @(negedge pclk);
        rst = 1'b1;
        cyc(300, 400, 0, 0);
        total += 2;
        if (xpos_out !== 12'd300) begin bad++; $display("FAIL release_x got=%0d exp=300", xpos_out); end
        if (ypos_out !== 12'd400) begin bad++; $display("FAIL release_y got=%0d exp=400", ypos_out); end
    endtask

    task automatic test_idle_clamp();
        cyc(2000, 2000, 0, 0);
        total += 2;
        if (xpos_out !== 12'd1232) begin bad++; $display("FAIL clamp_x got=%0d exp=1232", xpos_out); end
        if (ypos_out !== 12'd960) begin bad++; $display("FAIL clamp_y got=%0d exp=960", ypos_out); end
        cyc(100, 200, 0, 0);
        total += 2;
        if (xpos_out !== 12'd100) begin bad++; $display("FAIL follow_x got=%0d exp=100", xpos_out); end
        if (ypos_out !== 12'd200) begin bad++; $display("FAIL follow_y got=%0d exp=200", ypos_out); end
    endtask

    task automatic test_fall();
        int exp_y[4] = '{101, 103, 106, 110};
        cyc(100, 100, 0, 0);
        cyc(100, 100, 1, 0);
        total += 2;
        if (falling_out !== 1'b1) begin bad++; $display("FAIL click_fall got=%b exp=1", falling_out); end
        if (ypos_out !== 12'd100) begin bad++; $display("FAIL click_y got=%0d exp=100", ypos_out); end
        for (int i = 0; i < 4; i++) begin
            cyc($urandom_range(0, 4095), $urandom_range(0, 4095), 1, 1);
            total += 3;
            if (ypos_out !== 12'(exp_y[i])) begin bad++; $display("FAIL fall_y[%0d] got=%0d exp=%0d", i, ypos_out, exp_y[i]); end
            if (xpos_out !== 12'd100) begin bad++; $display("FAIL fall_x[%0d] got=%0d exp=100", i, xpos_out); end
            if (falling_out !== 1'b1) begin bad++; $display("FAIL fall_flag[%0d] got=%b exp=1", i, falling_out); end
            cyc($urandom_range(0, 4095), $urandom_range(0, 4095), 1, 0);
        end
    endtask

    task automatic test_land();
        int n = 0;
        while (m_st != 2 && n < 400) begin
            cyc($urandom_range(0, 4095), $urandom_range(0, 4095), 1, 1);
            total += 2;
            if (ypos_out > 12'd960) begin bad++; $display("FAIL overshoot got=%0d exp<=960", ypos_out); end
            if (ypos_out !== 12'(ey)) begin bad++; $display("FAIL drop_y got=%0d exp=%0d", ypos_out, ey); end
            cyc($urandom_range(0, 4095), $urandom_range(0, 4095), 1, 0);
            n++;
        end
        total += 3;
        if (n >= 400) begin bad++; $display("FAIL land_timeout ticks=%0d exp<400", n); end
        if (ypos_out !== 12'd960) begin bad++; $display("FAIL land_y got=%0d exp=960", ypos_out); end
        if (falling_out !== 1'b0) begin bad++; $display("FAIL land_fall got=%b exp=0", falling_out); end
        for (int i = 0; i < 3; i++) begin
            cyc($urandom_range(0, 4095), $urandom_range(0, 4095), 1, i[0]);
            total += 2;
            if (ypos_out !== 12'd960 || xpos_out !== 12'd100) begin bad++; $display("FAIL held_pos got=%0d,%0d exp=100,960", xpos_out, ypos_out); end
            if (falling_out !== 1'b0) begin bad++; $display("FAIL held_fall got=%b exp=0", falling_out); end
        end
        cyc(700, 500, 0, 0);
        cyc(700, 500, 1, 0);
        total += 1;
        if (ypos_out !== 12'd960) begin bad++; $display("FAIL return_hold_y got=%0d exp=960", ypos_out); end
        cyc(700, 500, 1, 0);
        total += 3;
        if (xpos_out !== 12'd700) begin bad++; $display("FAIL return_x got=%0d exp=700", xpos_out); end
        if (ypos_out !== 12'd500) begin bad++; $display("FAIL return_y got=%0d exp=500", ypos_out); end
        if (falling_out !== 1'b0) begin bad++; $display("FAIL return_fall got=%b exp=0", falling_out); end
    endtask

    task automatic test_press_tick();
        cyc(500, 300, 0, 0);
        cyc(500, 300, 1, 1);
        total += 3;
        if (falling_out !== 1'b1) begin bad++; $display("FAIL pt_fall got=%b exp=1", falling_out); end
        if (ypos_out !== 12'd300) begin bad++; $display("FAIL pt_y got=%0d exp=300", ypos_out); end
        if (xpos_out !== 12'd500) begin bad++; $display("FAIL pt_x got=%0d exp=500", xpos_out); end
        cyc(500, 300, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(500, 300, 1, 1);
            total += 1;
            if (ypos_out !== 12'd301) begin bad++; $display("FAIL vsync_held[%0d] got=%0d exp=301", i, ypos_out); end
        end
    endtask

    task automatic test_reset_mid();
        xpos_in = '0; ypos_in = '0; mouse_left_in = 0; vsync_in = 0;
        #2 rst = 1'b0;
        #1;
        total += 3;
        if (xpos_out !== 12'd0) begin bad++; $display("FAIL mid_rst_x got=%0d exp=0", xpos_out); end
        if (ypos_out !== 12'd0) begin bad++; $display("FAIL mid_rst_y got=%0d exp=0", ypos_out); end
        if (falling_out !== 1'b0) begin bad++; $display("FAIL mid_rst_fall got=%b exp=0", falling_out); end
        model_reset();
        repeat (2) @(negedge pclk);
        rst = 1'b1;
        cyc(800, 900, 0, 0);
        total += 3;
        if (xpos_out !== 12'd800) begin bad++; $display("FAIL mid_rel_x got=%0d exp=800", xpos_out); end
        if (ypos_out !== 12'd900) begin bad++; $display("FAIL mid_rel_y got=%0d exp=900", ypos_out); end
        if (falling_out !== 1'b0) begin bad++; $display("FAIL mid_rel_fall got=%b exp=0", falling_out); end
    endtask

    task automatic test_start_at_bottom();
        cyc(10, 2000, 0, 0);
        cyc(10, 2000, 1, 0);
        total += 1;
        if (falling_out !== 1'b1) begin bad++; $display("FAIL bottom_click got=%b exp=1", falling_out); end
        cyc(10, 2000, 1, 1);
        total += 2;
        if (ypos_out !== 12'd960) begin bad++; $display("FAIL bottom_y got=%0d exp=960", ypos_out); end
        if (falling_out !== 1'b0) begin bad++; $display("FAIL bottom_land got=%b exp=0", falling_out); end
    endtask

    task automatic test_random();
        int x = 0, y = 0;
        bit l = 0, v = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) begin x = $urandom_range(0, 4095); y = $urandom_range(0, 4095); end
            if ($urandom_range(0, 29) == 0) l = ~l;
            if ($urandom_range(0, 3) == 0) v = ~v;
            cyc(x, y, l, v);
            total += 3;
            if (xpos_out !== 12'(ex)) begin bad++; $display("FAIL rnd_x cyc=%0d got=%0d exp=%0d", i, xpos_out, ex); end
            if (ypos_out !== 12'(ey)) begin bad++; $display("FAIL rnd_y cyc=%0d got=%0d exp=%0d", i, ypos_out, ey); end
            if (falling_out !== ef) begin bad++; $display("FAIL rnd_fall cyc=%0d got=%b exp=%b", i, falling_out, ef); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_clamp();
        test_fall();
        test_land();
        test_press_tick();
        test_reset_mid();
        test_start_at_bottom();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
